// File: rtl/pc_stack_unit.sv
// Program-counter unit for the tinyrv core with an internal return-address stack.
// Reports PC misalignment and return-stack overflow/underflow as sticky faults.
module pc_stack_unit #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              INCR      = 4,
  parameter int              DEPTH     = 4,
  parameter int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcflag,
  input  logic             interrupt,
  input  logic [1:0]       jump,
  input  logic [PC_W-1:0]  imm,
  input  logic [PC_W-1:0]  isr_target,
  input  logic             clr_err,
  output logic [PC_W-1:0]  pc,
  output logic             pc_misaligned,
  output logic             misalign_sticky,
  output logic             in_isr,
  output logic [CNT_W-1:0] stack_count,
  output logic             stack_overflow,
  output logic             stack_underflow
);

  localparam int ALB   = (INCR == 4) ? 2 : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_count;
  logic             r_mis_sticky;
  logic             r_ovf;
  logic             r_unf;
  logic [PC_W-1:0]  r_stack [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_mret;
  logic [CNT_W-1:0] w_cnt_m1;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_cnt_idx;
  logic [PC_W-1:0]  w_top;
  logic [PC_W-1:0]  w_next_seq;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pc_load;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [PC_W-1:0]  w_wr_data;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_mis_set;

  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_mret    = pcflag && (jump == 2'b11);
  assign w_cnt_m1  = r_count - CNT_W'(1);
  assign w_top_idx = w_cnt_m1[IDX_W-1:0];
  assign w_cnt_idx = r_count[IDX_W-1:0];
  assign w_top     = w_empty ? RESET_VEC : r_stack[w_top_idx];

  // Candidate next PC from the control FSM; also the address pushed on an interrupt.
  always_comb begin
    w_next_seq = r_pc;
    if (pcflag) begin
      case (jump)
        2'b00:   w_next_seq = r_pc + imm;
        2'b01:   w_next_seq = imm;
        2'b10:   w_next_seq = r_pc + PC_W'(INCR);
        2'b11:   w_next_seq = w_top;
        default: w_next_seq = r_pc;
      endcase
    end else begin
      w_next_seq = r_pc;
    end
  end

  // Priority resolution: interrupt over pcflag over hold, with stack push/pop decisions.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_cnt_nxt = r_count;
    w_pc_load = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_idx  = w_cnt_idx;
    w_wr_data = w_next_seq;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (interrupt) begin
      w_pc_nxt  = isr_target;
      w_pc_load = 1'b1;
      if (w_mret) begin
        // Pop-then-push: the popped value (or RESET_VEC) lands back on top.
        w_wr_en = 1'b1;
        if (w_empty) begin
          w_wr_idx  = {IDX_W{1'b0}};
          w_cnt_nxt = CNT_W'(1);
          w_unf_set = 1'b1;
        end else begin
          w_wr_idx  = w_top_idx;
        end
      end else if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr_en   = 1'b1;
        w_wr_idx  = w_cnt_idx;
        w_cnt_nxt = r_count + CNT_W'(1);
      end
    end else if (pcflag) begin
      w_pc_nxt  = w_next_seq;
      w_pc_load = 1'b1;
      if (w_mret) begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_m1;
        end
      end else begin
        w_cnt_nxt = r_count;
      end
    end else begin
      w_pc_nxt  = r_pc;
    end
  end

  assign w_mis_set = w_pc_load && (w_pc_nxt[ALB-1:0] != {ALB{1'b0}});

  // PC, stack depth and sticky fault registers; a same-cycle fault beats clr_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_VEC;
      r_count      <= {CNT_W{1'b0}};
      r_mis_sticky <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_count      <= w_cnt_nxt;
      r_mis_sticky <= (r_mis_sticky & ~clr_err) | w_mis_set;
      r_ovf        <= (r_ovf & ~clr_err) | w_ovf_set;
      r_unf        <= (r_unf & ~clr_err) | w_unf_set;
    end
  end

  // Return-address storage; contents are meaningful only below r_count.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      r_stack[w_wr_idx] <= w_wr_data;
    end
  end

  assign pc              = r_pc;
  assign pc_misaligned   = (r_pc[ALB-1:0] != {ALB{1'b0}});
  assign misalign_sticky = r_mis_sticky;
  assign in_isr          = !w_empty;
  assign stack_count     = r_count;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a word-aligned (INCR=4) unit and a
// halfword-aligned (INCR=2) unit driven by the same inputs.
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        reset, pcflag, interrupt, clr_err;
  logic [1:0]  jump;
  logic [15:0] imm, isr_target;

  logic [15:0] pc4, pc2;
  logic        mis4, mis2, stk4, stk2, isr4, isr2, ovf4, ovf2, unf4, unf2;
  logic [2:0]  cnt4, cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(.PC_W(16), .RESET_VEC(16'h0100), .INCR(4), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .pcflag(pcflag), .interrupt(interrupt), .jump(jump),
    .imm(imm), .isr_target(isr_target), .clr_err(clr_err), .pc(pc4),
    .pc_misaligned(mis4), .misalign_sticky(stk4), .in_isr(isr4), .stack_count(cnt4),
    .stack_overflow(ovf4), .stack_underflow(unf4));

  pc_stack_unit #(.PC_W(16), .RESET_VEC(16'h0100), .INCR(2), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .pcflag(pcflag), .interrupt(interrupt), .jump(jump),
    .imm(imm), .isr_target(isr_target), .clr_err(clr_err), .pc(pc2),
    .pc_misaligned(mis2), .misalign_sticky(stk2), .in_isr(isr2), .stack_count(cnt2),
    .stack_overflow(ovf2), .stack_underflow(unf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pf, input logic [1:0] j, input logic [15:0] im,
                       input logic irq, input logic [15:0] tgt);
    pcflag = pf; jump = j; imm = im; interrupt = irq; isr_target = tgt;
  endtask

  initial begin
    reset = 1'b1; clr_err = 1'b0;
    drive(1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000);
    tick(); tick();
    chk("rst_pc", pc4, 16'h0100);
    chk("rst_cnt", cnt4, 3'd0);
    chk("rst_flags", {mis4, stk4, isr4, ovf4, unf4}, 5'b00000);

    // Sequential fetch
    reset = 1'b0;
    drive(1'b1, 2'b10, 16'h0000, 1'b0, 16'h0000);
    tick(); chk("seq1", pc4, 16'h0104);
    tick(); chk("seq2", pc4, 16'h0108);
    tick(); chk("seq3", pc4, 16'h010C);
    chk("seq_flags", {mis4, stk4, isr4, ovf4, unf4}, 5'b00000);

    // Wrap-around
    drive(1'b1, 2'b01, 16'hFFFC, 1'b0, 16'h0000); tick(); chk("abs_fffc", pc4, 16'hFFFC);
    drive(1'b1, 2'b10, 16'h0000, 1'b0, 16'h0000); tick(); chk("wrap_seq", pc4, 16'h0000);
    drive(1'b1, 2'b01, 16'hFFFC, 1'b0, 16'h0000); tick();
    drive(1'b1, 2'b00, 16'h0008, 1'b0, 16'h0000); tick(); chk("wrap_rel", pc4, 16'h0004);

    // Nested interrupts and return
    drive(1'b1, 2'b01, 16'h0040, 1'b0, 16'h0000); tick();
    drive(1'b1, 2'b10, 16'h0000, 1'b1, 16'h0200); tick();
    chk("irq1_pc", pc4, 16'h0200); chk("irq1_cnt", cnt4, 3'd1); chk("irq1_isr", isr4, 1'b1);
    drive(1'b1, 2'b01, 16'h0208, 1'b0, 16'h0000); tick(); chk("isr_jump", pc4, 16'h0208);
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0300); tick();
    chk("irq2_pc", pc4, 16'h0300); chk("irq2_cnt", cnt4, 3'd2);
    drive(1'b1, 2'b11, 16'h0000, 1'b0, 16'h0000); tick();
    chk("mret1_pc", pc4, 16'h0208); chk("mret1_cnt", cnt4, 3'd1);
    tick();
    chk("mret2_pc", pc4, 16'h0044); chk("mret2_cnt", cnt4, 3'd0); chk("mret2_isr", isr4, 1'b0);

    // Overflow: five interrupts into a four-deep stack
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0400); tick();
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0500); tick();
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0600); tick();
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0700); tick();
    chk("irq4_cnt", cnt4, 3'd4); chk("irq4_ovf", ovf4, 1'b0);
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0800); tick();
    chk("irq5_pc", pc4, 16'h0800); chk("irq5_cnt", cnt4, 3'd4); chk("irq5_ovf", ovf4, 1'b1);

    // Unwind the stack, then underflow
    drive(1'b1, 2'b11, 16'h0000, 1'b0, 16'h0000);
    tick(); chk("pop1", {pc4, 13'd0, cnt4}, {16'h0600, 13'd0, 3'd3});
    tick(); chk("pop2", {pc4, 13'd0, cnt4}, {16'h0500, 13'd0, 3'd2});
    tick(); chk("pop3", {pc4, 13'd0, cnt4}, {16'h0400, 13'd0, 3'd1});
    tick(); chk("pop4", {pc4, 13'd0, cnt4}, {16'h0044, 13'd0, 3'd0});
    chk("pop4_unf", unf4, 1'b0);
    tick(); chk("pop5_pc", pc4, 16'h0100); chk("pop5_cnt", cnt4, 3'd0); chk("pop5_unf", unf4, 1'b1);
    drive(1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000); clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_flags", {ovf4, unf4}, 2'b00);
    chk("clr_hold_pc", pc4, 16'h0100);

    // Simultaneous MRET and interrupt with one entry
    drive(1'b1, 2'b01, 16'h0080, 1'b0, 16'h0000); tick();
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0900); tick(); chk("pre_cnt", cnt4, 3'd1);
    drive(1'b1, 2'b11, 16'h0000, 1'b1, 16'h0A00); tick();
    chk("swap_pc", pc4, 16'h0A00); chk("swap_cnt", cnt4, 3'd1); chk("swap_unf", unf4, 1'b0);
    drive(1'b1, 2'b11, 16'h0000, 1'b0, 16'h0000); tick();
    chk("swap_ret", pc4, 16'h0080); chk("swap_ret_cnt", cnt4, 3'd0);

    // Simultaneous MRET and interrupt on an empty stack
    drive(1'b1, 2'b11, 16'h0000, 1'b1, 16'h0B00); tick();
    chk("eswap_pc", pc4, 16'h0B00); chk("eswap_cnt", cnt4, 3'd1); chk("eswap_unf", unf4, 1'b1);
    drive(1'b1, 2'b11, 16'h0000, 1'b0, 16'h0000); tick();
    chk("eswap_ret", pc4, 16'h0100); chk("eswap_ret_cnt", cnt4, 3'd0);

    // clr_err loses to a fault raised in the same cycle
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_vs_set", unf4, 1'b1);
    drive(1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000); clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_unf", unf4, 1'b0);

    // Misalignment: faults at INCR=4, not at INCR=2
    drive(1'b1, 2'b01, 16'h0102, 1'b0, 16'h0000); tick();
    chk("mis4_pc", pc4, 16'h0102); chk("mis4_flags", {mis4, stk4}, 2'b11);
    chk("mis2_pc", pc2, 16'h0102); chk("mis2_flags", {mis2, stk2}, 2'b00);
    drive(1'b1, 2'b01, 16'h0104, 1'b0, 16'h0000); tick();
    chk("realign_flags", {mis4, stk4}, 2'b01);
    drive(1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000); clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_mis", stk4, 1'b0);

    // Reset in the middle of an interrupt discards the push
    drive(1'b0, 2'b10, 16'h0000, 1'b1, 16'h0C00); tick(); chk("prerst_cnt", cnt4, 3'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b0, 2'b10, 16'h0000, 1'b0, 16'h0000);
    chk("midrst_pc", pc4, 16'h0100); chk("midrst_cnt", cnt4, 3'd0);
    chk("midrst_isr", isr4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
